// File: rtl/sprite_fetch_pipeline_if.sv
// Read bus shared by the sprite-sheet and background memories.
// Both ports are strobed together by rd_en.
interface sprite_fetch_pipeline_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] spr_addr;
    logic [ADDR_W-1:0] bg_addr;
    logic              rd_en;
    logic [DATA_W-1:0] spr_data;
    logic [DATA_W-1:0] bg_data;

    modport master (
        output spr_addr,
        output bg_addr,
        output rd_en,
        input  spr_data,
        input  bg_data
    );

    modport slave (
        input  spr_addr,
        input  bg_addr,
        input  rd_en,
        output spr_data,
        output bg_data
    );
endinterface

// File: rtl/sprite_fetch_pipeline.sv
// Sprite/background address generator and compositor: one pixel per cycle,
// side-band realigned with read data that returns MEM_LAT cycles after the address.
module sprite_fetch_pipeline #(
    parameter int              NUM_SPR   = 8,
    parameter int              IDX_W     = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1,
    parameter int              COORD_W   = 10,
    parameter int              ADDR_W    = 20,
    parameter int              DATA_W    = 16,
    parameter int              SHEET_W   = 640,
    parameter int              MEM_LAT   = 2,
    parameter logic [DATA_W-1:0] KEY_COLOR = 16'hF81F
) (
    input  logic                        Clk,
    input  logic                        Reset_n,
    input  logic                        pix_valid,
    input  logic [COORD_W-1:0]          DrawX,
    input  logic [COORD_W-1:0]          DrawY,
    input  logic [NUM_SPR-1:0]          spr_hit,
    input  logic [NUM_SPR*COORD_W-1:0]  spr_off_x,
    input  logic [NUM_SPR*COORD_W-1:0]  spr_off_y,
    input  logic                        desc_we,
    input  logic [IDX_W-1:0]            desc_idx,
    input  logic [ADDR_W-1:0]           desc_base_x,
    input  logic [ADDR_W-1:0]           desc_base_y,
    input  logic                        desc_en,
    input  logic                        desc_key_en,
    sprite_fetch_pipeline_if.master     mem,
    output logic [DATA_W-1:0]           pix_out,
    output logic                        pix_out_valid,
    output logic [IDX_W-1:0]            hit_idx_out,
    output logic                        hit_any_out
);

    localparam logic [ADDR_W-1:0] SHEET_A = ADDR_W'(SHEET_W);

    logic [1:0] rst_sync;
    logic       rst_n;

    logic [ADDR_W-1:0] d_bx  [NUM_SPR];
    logic [ADDR_W-1:0] d_by  [NUM_SPR];
    logic              d_en  [NUM_SPR];
    logic              d_key [NUM_SPR];

    logic              win;
    logic [IDX_W-1:0]  win_idx;
    logic              win_key;
    logic [ADDR_W-1:0] sel_bx, sel_by, sel_ox, sel_oy;
    logic [ADDR_W-1:0] spr_addr_nxt, bg_addr_nxt;

    logic              s1_hit;
    logic [IDX_W-1:0]  s1_idx;
    logic              s1_key;

    logic              sb_vld [MEM_LAT];
    logic              sb_hit [MEM_LAT];
    logic [IDX_W-1:0]  sb_idx [MEM_LAT];
    logic              sb_key [MEM_LAT];

    logic              use_spr;

    // Assert asynchronously, release two edges after Reset_n rises.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) rst_sync <= 2'b00;
        else          rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SPR; i++) begin
                d_bx[i]  <= '0;
                d_by[i]  <= '0;
                d_en[i]  <= 1'b0;
                d_key[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < NUM_SPR; i++) begin
                if (desc_we && desc_idx == IDX_W'(i)) begin
                    d_bx[i]  <= desc_base_x;
                    d_by[i]  <= desc_base_y;
                    d_en[i]  <= desc_en;
                    d_key[i] <= desc_key_en;
                end
            end
        end
    end

    // Ascending scan so the highest enabled hit ends up on top.
    always_comb begin
        win     = 1'b0;
        win_idx = '0;
        win_key = 1'b0;
        sel_bx  = '0;
        sel_by  = '0;
        sel_ox  = '0;
        sel_oy  = '0;
        for (int i = 0; i < NUM_SPR; i++) begin
            if (spr_hit[i] && d_en[i]) begin
                win     = 1'b1;
                win_idx = IDX_W'(i);
                win_key = d_key[i];
                sel_bx  = d_bx[i];
                sel_by  = d_by[i];
                sel_ox  = ADDR_W'(spr_off_x[i*COORD_W +: COORD_W]);
                sel_oy  = ADDR_W'(spr_off_y[i*COORD_W +: COORD_W]);
            end
        end
    end

    assign spr_addr_nxt = win ? ((sel_by + sel_oy) * SHEET_A + sel_bx + sel_ox) : '0;
    assign bg_addr_nxt  = ADDR_W'(DrawY) * SHEET_A + ADDR_W'(DrawX);

    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            mem.spr_addr <= '0;
            mem.bg_addr  <= '0;
            mem.rd_en    <= 1'b0;
            s1_hit       <= 1'b0;
            s1_idx       <= '0;
            s1_key       <= 1'b0;
        end else begin
            mem.rd_en <= pix_valid;
            if (pix_valid) begin
                mem.spr_addr <= spr_addr_nxt;
                mem.bg_addr  <= bg_addr_nxt;
                s1_hit       <= win;
                s1_idx       <= win_idx;
                s1_key       <= win_key;
            end
        end
    end

    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MEM_LAT; i++) begin
                sb_vld[i] <= 1'b0;
                sb_hit[i] <= 1'b0;
                sb_idx[i] <= '0;
                sb_key[i] <= 1'b0;
            end
        end else begin
            sb_vld[0] <= mem.rd_en;
            sb_hit[0] <= s1_hit;
            sb_idx[0] <= s1_idx;
            sb_key[0] <= s1_key;
            for (int i = 1; i < MEM_LAT; i++) begin
                sb_vld[i] <= sb_vld[i-1];
                sb_hit[i] <= sb_hit[i-1];
                sb_idx[i] <= sb_idx[i-1];
                sb_key[i] <= sb_key[i-1];
            end
        end
    end

    assign use_spr = sb_hit[MEM_LAT-1] &&
                     !(sb_key[MEM_LAT-1] && mem.spr_data == KEY_COLOR);

    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_out       <= '0;
            pix_out_valid <= 1'b0;
            hit_idx_out   <= '0;
            hit_any_out   <= 1'b0;
        end else begin
            pix_out_valid <= sb_vld[MEM_LAT-1];
            if (sb_vld[MEM_LAT-1]) begin
                pix_out     <= use_spr ? mem.spr_data : mem.bg_data;
                hit_idx_out <= use_spr ? sb_idx[MEM_LAT-1] : '0;
                hit_any_out <= use_spr;
            end
        end
    end

endmodule

// File: doc/sprite_fetch_pipeline.md
Name: sprite_fetch_pipeline

Overview:
- Parametrised, pipelined sprite/background address generator and pixel compositor for the VGA path.
- Generalises the fixed per-object lookup to NUM_SPR sprite channels.
- Each channel has a runtime-writable descriptor (sheet base, enable, transparency enable).
- Block drives a sprite-sheet read port and a background read port in parallel, realigns returned data across memory latency, and emits one composited 16-bit pixel per valid input pixel to RGB_extender.

Parameters:
- NUM_SPR, 8, number of sprite channels; channel index width IDX_W = clog2(NUM_SPR).
- COORD_W, 10, width of DrawX/DrawY and sprite offsets.
- ADDR_W, 20, read address width, both ports.
- DATA_W, 16, pixel width.
- SHEET_W, 640, row pitch of the sprite sheet and of the background image.
- MEM_LAT, 2, read latency in cycles from address to data, both ports (≥1).
- KEY_COLOR, 16'hF81F, transparent colour key.

Ports:
- Clk, in, 1, clock.
- Reset_n, in, 1, asynchronous active-low reset.
- pix_valid, in, 1, DrawX/DrawY/hit/offsets valid this cycle.
- DrawX, in, COORD_W, screen x.
- DrawY, in, COORD_W, screen y.
- spr_hit, in, NUM_SPR, bit i set when the pixel lies inside sprite i.
- spr_off_x, in, NUM_SPR*COORD_W, flattened per-sprite x offsets; channel i at [i*COORD_W +: COORD_W].
- spr_off_y, in, NUM_SPR*COORD_W, flattened per-sprite y offsets; same packing.
- desc_we, in, 1, descriptor write strobe.
- desc_idx, in, IDX_W, descriptor to write.
- desc_base_x, in, ADDR_W, sheet x origin of the sprite.
- desc_base_y, in, ADDR_W, sheet y origin of the sprite.
- desc_en, in, 1, sprite enable.
- desc_key_en, in, 1, apply KEY_COLOR transparency.
- spr_addr, out, ADDR_W, sprite-sheet read address.
- spr_data, in, DATA_W, sprite-sheet read data.
- bg_addr, out, ADDR_W, background read address.
- bg_data, in, DATA_W, background read data.
- rd_en, out, 1, read strobe for both ports.
- pix_out, out, DATA_W, composited pixel.
- pix_out_valid, out, 1, pix_out valid.
- hit_idx_out, out, IDX_W, winning sprite index, aligned with pix_out; 0 when no sprite.
- hit_any_out, out, 1, a sprite pixel, not background, was output.

Behaviour:
- Reset (async assert, sync deassert internally):
  - all descriptors get en=0, key_en=0, base=0.
  - all pipeline valids cleared.
  - spr_addr, bg_addr, pix_out, hit_idx_out = 0.
  - rd_en, pix_out_valid, hit_any_out = 0.
- Reset mid-frame discards all in-flight pixels; no partial output is emitted after deassert.
- Descriptor write: on a Clk edge with desc_we=1, entry desc_idx is updated.
  - A pixel presented in the same cycle uses the OLD descriptor.
  - The new value applies from the next cycle.
  - desc_idx ≥ NUM_SPR is ignored.
- Stage S0 → S1, registered:
  - Winner = highest index i with spr_hit[i] && en[i] (higher index draws on top).
  - spr_addr = (base_y[w] + off_y[w]) * SHEET_W + base_x[w] + off_x[w], offsets zero-extended, result truncated mod 2^ADDR_W.
  - No winner: spr_addr = 0.
  - bg_addr = DrawY*SHEET_W + DrawX, same truncation.
  - rd_en = pix_valid. Addresses hold their last value when pix_valid=0.
- Side-band delay: valid, hit flag, winner index, and key_en captured at S0 travel through a MEM_LAT-deep shift register aligned with returned data.
- Output stage, registered:
  - pix_out = spr_data if hit && !(key_en && spr_data==KEY_COLOR), else bg_data.
  - hit_any_out = 1 only when spr_data was selected.
  - When pix_out_valid=0, pix_out holds its previous value.
- Latency: pix_out_valid asserts exactly MEM_LAT+2 cycles after the pix_valid cycle.
- Throughput: one pixel per cycle, no back-pressure; bubbles in pix_valid propagate unchanged.
- Disabled sprites never win, even if spr_hit is set.
- All hits disabled or absent → background.

Test Plan:
- Reset, no descriptors written; pix_valid=1, DrawX=5, DrawY=2, spr_hit=8'hFF → bg_addr=1285, spr_addr=0, after 4 cycles (MEM_LAT=2) pix_out=bg_data, hit_any_out=0.
- Write desc 3 (base_x=14, base_y=0, en=1); pixel with hit[3], off=(2,1) → spr_addr=656; spr_data=16'h1234 → pix_out=16'h1234, hit_idx_out=3, hit_any_out=1.
- Enable desc 1 and desc 5, hit both → spr_addr uses desc 5; clear en on desc 5 → next pixel uses desc 1.
- desc 3 with key_en=1, spr_data=16'hF81F → pix_out=bg_data, hit_any_out=0; key_en=0 with the same data → pix_out=16'hF81F.
- Write desc 2 base_y=486 in the same cycle as a hit-2 pixel → that pixel uses old base 0; the following pixel uses row 486 (addr 311040+x).
- Stream 10 pixels with pix_valid pattern 1101 repeated, then assert Reset_n=0 mid-stream → output valid pattern mirrors input delayed 4 cycles; after reset no pix_out_valid until new input, and all outputs are 0.
